gf_serial_frame: RTL and testbench
==================================

# gf_serial_frame

Framed serial I/O engine for the GF/carry-less arithmetic cores. It replaces free-running serial-in/serial-out shift registers with a controlled frame: start, load, execute, unload, done. It deserialises two operands over `LANES`-bit serial lanes and launches an attached core with a start/done handshake. It then serialises the core result and guards the execute phase with a timeout watchdog.

## Interface
- `DATA_WIDTH`, 32, operand width in bits; must be a multiple of `LANES`.
- `OUT_WIDTH`, 64, core result width in bits; must be a multiple of `LANES`.
- `LANES`, 1, serial lane width in bits; 1, 2, 4 or 8.
- `TIMEOUT`, 255, maximum EXEC cycles without `core_done` before abort; ≥ 2.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: frame request; honoured only in IDLE.
- `in_valid` in 1: load beat qualifier.
- `in_a` in LANES: operand A serial beat, MSB-first.
- `in_b` in LANES: operand B serial beat, MSB-first.
- `core_a` out DATA_WIDTH: operand A to core.
- `core_b` out DATA_WIDTH: operand B to core.
- `core_start` out 1: one-cycle launch pulse.
- `core_done` in 1: core completion strobe.
- `core_result` in OUT_WIDTH: core result, valid with `core_done`.
- `out_serial` out LANES: result serial beat, MSB-first.
- `out_valid` out 1: qualifies `out_serial`.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle frame-complete pulse.
- `error` out 1: sticky timeout flag.

## Operation
- Beat counts: N_IN = DATA_WIDTH/LANES and N_OUT = OUT_WIDTH/LANES.
- States are IDLE, LOAD, EXEC and UNLOAD.
- IDLE → LOAD on `start`. Accepting `start` clears `error` and the beat counter. Operand registers are not cleared.
- LOAD, on each `in_valid` cycle:
  - `core_a` ← {core_a[DATA_WIDTH-LANES-1:0], in_a}; `core_b` likewise.
  - The first beat therefore lands in the MSBs.
  - Cycles with `in_valid` low are gaps. They are allowed and do not advance the counter.
  - On beat N_IN: → EXEC.
- EXEC:
  - `core_start` is high on the first EXEC cycle only.
  - `core_done` is sampled only on later EXEC cycles. It is ignored in the `core_start` cycle and in every other state.
  - On `core_done`: capture `core_result` into the output shifter and → UNLOAD.
  - If `TIMEOUT` EXEC cycles elapse without `core_done` (counting the `core_start` cycle): → IDLE, `error` ← 1, no `done` pulse.
- UNLOAD:
  - `out_serial` = shifter[OUT_WIDTH-1 -: LANES] with `out_valid` high, for N_OUT consecutive cycles (no backpressure).
  - The shifter shifts left by LANES each cycle.
  - After the last beat: → IDLE with `done` high for that one IDLE cycle.
- `start` outside IDLE and `in_valid` outside LOAD are ignored.
- `core_a`/`core_b` hold from the end of LOAD until the next LOAD beat.
- Reset in any state, including mid-LOAD and mid-UNLOAD:
  - State → IDLE immediately.
  - Every output → 0 (`core_a`, `core_b`, `core_start`, `out_serial`, `out_valid`, `busy`, `done`, `error`). Internal counters and the shifter also → 0.
  - No `done` is issued for the aborted frame.

## Timing
- `start` high at edge t: LOAD, `busy`=1 from t+1. The earliest load beat is sampled at t+1.
- Last load beat sampled at edge c: EXEC from c+1, with `core_start`=1 during c+1 only.
- `core_done` sampled at edge d (d ≥ c+2): UNLOAD from d+1. Beat k is presented during d+1+k, k = 0..N_OUT-1.
- `done`=1 and `busy`=0 during d+1+N_OUT.
- A new `start` is accepted in that same `done` cycle.
- Timeout: `core_done` never arrives → IDLE and `error`=1 from cycle c+1+TIMEOUT.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
1. DATA_WIDTH=8, OUT_WIDTH=16, LANES=1.
   - Stimulus: load A=0xA5, B=0x3C; the core model returns {A,B} three cycles after `core_start`.
   - Required: `core_a`=0xA5, `core_b`=0x3C; `out_serial` streams 0xA53C MSB-first over 16 cycles; `done` in the cycle after the last beat.
2. LANES=4, DATA_WIDTH=32.
   - Stimulus: load 0x12345678 in 8 beats with `in_valid` gaps after beats 2 and 5.
   - Required: `core_a`=0x12345678; `core_start` exactly once, in the cycle after beat 8.
3. TIMEOUT=4, core never asserts `core_done`.
   - Required: IDLE and `error`=1 four EXEC cycles after entry; no `done`.
   - Next `start` clears `error`.
4. `start` and `in_valid` pulsed during EXEC and UNLOAD.
   - Required: no effect on state, operands or output stream.
   - `core_done` held high during the `core_start` cycle is not accepted.
5. `reset` asserted mid-UNLOAD (beat 5 of 16).
   - Required: all outputs 0 asynchronously, IDLE, no `done`.
   - A following full frame completes correctly.
6. Back-to-back frames.
   - Stimulus: `start` asserted in the `done` cycle.
   - Required: second frame enters LOAD next cycle; result of frame 1 is unaffected.

Source files
------------

// File: rtl/gf_serial_frame.sv
// Framed serial I/O engine for GF/carry-less cores.
// A frame has four phases: the engine is started, it loads two operands as
// MSB-first serial beats, it runs the attached core under a timeout watchdog,
// and it unloads the core result as MSB-first serial beats.
module gf_serial_frame #(
   parameter int DATA_WIDTH = 32,
   parameter int OUT_WIDTH  = 64,
   parameter int LANES      = 1,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [LANES-1:0]      in_a,
   input  logic [LANES-1:0]      in_b,
   output logic [DATA_WIDTH-1:0] core_a,
   output logic [DATA_WIDTH-1:0] core_b,
   output logic                  core_start,
   input  logic                  core_done,
   input  logic [OUT_WIDTH-1:0]  core_result,
   output logic [LANES-1:0]      out_serial,
   output logic                  out_valid,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int N_IN    = DATA_WIDTH / LANES;
   localparam int N_OUT   = OUT_WIDTH / LANES;
   localparam int MAX_IO  = (N_IN > N_OUT) ? N_IN : N_OUT;
   localparam int MAX_CNT = (MAX_IO > TIMEOUT) ? MAX_IO : TIMEOUT;
   localparam int CW      = $clog2(MAX_CNT + 1);

   localparam logic [CW-1:0] LAST_IN   = CW'(N_IN - 1);
   localparam logic [CW-1:0] LAST_OUT  = CW'(N_OUT - 1);
   localparam logic [CW-1:0] LAST_EXEC = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_EXEC   = 2'd2,
      S_UNLOAD = 2'd3
   } state_t;

   state_t                state_r, state_nxt_s;
   logic [CW-1:0]         cnt_r;
   logic [DATA_WIDTH-1:0] core_a_r, core_b_r;
   logic [OUT_WIDTH-1:0]  shift_r;
   logic                  core_start_r, out_valid_r, busy_r, done_r, error_r;
   logic                  core_start_nxt_s, out_valid_nxt_s, busy_nxt_s;
   logic                  done_nxt_s, error_nxt_s;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; core_done only counts after the launch cycle, and it
   // beats the watchdog when both land on the final EXEC cycle.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start) state_nxt_s = S_LOAD;
            else       state_nxt_s = S_IDLE;
         end
         S_LOAD: begin
            if (in_valid && (cnt_r == LAST_IN)) state_nxt_s = S_EXEC;
            else                                state_nxt_s = S_LOAD;
         end
         S_EXEC: begin
            if (core_done && !core_start_r) state_nxt_s = S_UNLOAD;
            else if (cnt_r == LAST_EXEC)    state_nxt_s = S_IDLE;
            else                            state_nxt_s = S_EXEC;
         end
         S_UNLOAD: begin
            if (cnt_r == LAST_OUT) state_nxt_s = S_IDLE;
            else                   state_nxt_s = S_UNLOAD;
         end
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // Next values of the registered status outputs, derived from the transition.
   always_comb begin
      busy_nxt_s       = (state_nxt_s != S_IDLE);
      out_valid_nxt_s  = (state_nxt_s == S_UNLOAD);
      core_start_nxt_s = (state_r == S_LOAD) && (state_nxt_s == S_EXEC);
      done_nxt_s       = (state_r == S_UNLOAD) && (state_nxt_s == S_IDLE);
      if ((state_r == S_IDLE) && start) begin
         error_nxt_s = 1'b0;
      end else if ((state_r == S_EXEC) && (state_nxt_s == S_IDLE)) begin
         error_nxt_s = 1'b1;
      end else begin
         error_nxt_s = error_r;
      end
   end

   // Datapath: beat counter, operand deserialisers, result shifter, status flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r        <= CNT_ZERO;
         core_a_r     <= '0;
         core_b_r     <= '0;
         shift_r      <= '0;
         core_start_r <= 1'b0;
         out_valid_r  <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         error_r      <= 1'b0;
      end else begin
         core_start_r <= core_start_nxt_s;
         out_valid_r  <= out_valid_nxt_s;
         busy_r       <= busy_nxt_s;
         done_r       <= done_nxt_s;
         error_r      <= error_nxt_s;
         case (state_r)
            S_IDLE: begin
               if (start) cnt_r <= CNT_ZERO;
            end
            S_LOAD: begin
               if (in_valid) begin
                  core_a_r <= {core_a_r[DATA_WIDTH-LANES-1:0], in_a};
                  core_b_r <= {core_b_r[DATA_WIDTH-LANES-1:0], in_b};
                  cnt_r    <= (cnt_r == LAST_IN) ? CNT_ZERO : (cnt_r + CNT_ONE);
               end
            end
            S_EXEC: begin
               if (state_nxt_s == S_UNLOAD) begin
                  shift_r <= core_result;
                  cnt_r   <= CNT_ZERO;
               end else if (state_nxt_s == S_IDLE) begin
                  cnt_r   <= CNT_ZERO;
               end else begin
                  cnt_r   <= cnt_r + CNT_ONE;
               end
            end
            S_UNLOAD: begin
               // Shifting zeros in leaves the shifter empty once the frame ends,
               // so out_serial idles at zero.
               shift_r <= {shift_r[OUT_WIDTH-LANES-1:0], {LANES{1'b0}}};
               cnt_r   <= (cnt_r == LAST_OUT) ? CNT_ZERO : (cnt_r + CNT_ONE);
            end
            default: cnt_r <= CNT_ZERO;
         endcase
      end
   end

   assign core_a     = core_a_r;
   assign core_b     = core_b_r;
   assign core_start = core_start_r;
   assign out_serial = shift_r[OUT_WIDTH-1 -: LANES];
   assign out_valid  = out_valid_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign error      = error_r;

endmodule

// File: tb/tb_gf_serial_frame.sv
// Self-checking bench for gf_serial_frame (32-bit operands, 4-bit lanes,
// 64-bit result, TIMEOUT=4). The expected values come from a reference model:
// the core result is {A,B}, and expected beat k is bits [63-4k -: 4] of it.
module tb_gf_serial_frame;

   localparam int DW = 32;
   localparam int OW = 64;
   localparam int LN = 4;
   localparam int TO = 4;
   localparam int NI = DW / LN;
   localparam int NO = OW / LN;

   logic          clk = 1'b0;
   logic          reset, start, in_valid, core_done;
   logic [LN-1:0] in_a, in_b;
   logic [DW-1:0] core_a, core_b;
   logic          core_start, out_valid, busy, done, error;
   logic [OW-1:0] core_result;
   logic [LN-1:0] out_serial;

   int n_tests = 0;
   int n_fail  = 0;

   gf_serial_frame #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .LANES(LN), .TIMEOUT(TO)) u_dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
      .in_a(in_a), .in_b(in_b), .core_a(core_a), .core_b(core_b),
      .core_start(core_start), .core_done(core_done), .core_result(core_result),
      .out_serial(out_serial), .out_valid(out_valid), .busy(busy),
      .done(done), .error(error)
   );

   always #5 clk = ~clk;

   // One frame. lat = 0 means the core never answers (timeout path); lat > 0
   // raises core_done lat cycles after the core_start cycle. With noise set,
   // start/in_valid are pulsed during EXEC/UNLOAD, and core_done is held high
   // with a wrong result during the core_start cycle. abort_k >= 0 resets
   // the DUT during unload beat abort_k.
   task automatic do_frame(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input int gap_mode, input int lat, input bit noise,
                           input int abort_k, input bit pre_started, input bit chain);
      logic [OW-1:0] res;
      logic [LN-1:0] exp_beat;
      res = {a, b};
      if (!pre_started) begin
         @(posedge clk); #1;
         start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      n_tests++;
      if ({busy, done, error, core_start} !== 4'b1000) begin
         n_fail++;
         $display("FAIL load_entry: busy/done/error/core_start=%b expected 1000", {busy, done, error, core_start});
      end
      for (int i = 0; i < NI; i++) begin
         bit gap;
         gap = ((gap_mode == 1) && (i == 2 || i == 5)) ||
               ((gap_mode == 2) && ($urandom_range(0, 1) == 1));
         if (gap) begin
            in_valid = 1'b0;
            in_a = LN'($urandom);
            in_b = LN'($urandom);
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_a = LN'(a >> (DW - LN * (i + 1)));
         in_b = LN'(b >> (DW - LN * (i + 1)));
         @(posedge clk); #1;
         in_valid = 1'b0;
         if (i < NI - 1) begin
            n_tests++;
            if (core_start !== 1'b0 || busy !== 1'b1) begin
               n_fail++;
               $display("FAIL load_beat%0d: core_start=%b busy=%b expected 0 1", i, core_start, busy);
            end
         end
      end
      n_tests++;
      if (core_start !== 1'b1 || core_a !== a || core_b !== b) begin
         n_fail++;
         $display("FAIL exec_entry: core_start=%b a=%h b=%h expected 1 %h %h", core_start, core_a, core_b, a, b);
      end
      if (noise) begin
         core_done   = 1'b1;
         core_result = ~res;
      end
      if (lat == 0) begin
         for (int j = 1; j < TO; j++) begin
            @(posedge clk); #1;
            n_tests++;
            if ({busy, error, core_start, done} !== 4'b1000) begin
               n_fail++;
               $display("FAIL exec_wait%0d: busy/error/core_start/done=%b expected 1000", j, {busy, error, core_start, done});
            end
         end
         @(posedge clk); #1;
         n_tests++;
         if ({busy, error, done, out_valid} !== 4'b0100) begin
            n_fail++;
            $display("FAIL timeout: busy/error/done/out_valid=%b expected 0100", {busy, error, done, out_valid});
         end
         for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            n_tests++;
            if (done !== 1'b0 || error !== 1'b1) begin
               n_fail++;
               $display("FAIL timeout_sticky: done=%b error=%b expected 0 1", done, error);
            end
         end
         return;
      end
      for (int j = 1; j <= lat; j++) begin
         if (noise) begin
            start    = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            in_a     = LN'($urandom);
            in_b     = LN'($urandom);
         end
         @(posedge clk); #1;
         core_done = 1'b0;
         n_tests++;
         if ({core_start, busy, out_valid} !== 3'b010) begin
            n_fail++;
            $display("FAIL exec%0d: core_start/busy/out_valid=%b expected 010", j, {core_start, busy, out_valid});
         end
         if (j == lat) begin
            core_done   = 1'b1;
            core_result = res;
         end
      end
      @(posedge clk); #1;
      core_done   = 1'b0;
      core_result = {$urandom, $urandom};
      start       = 1'b0;
      in_valid    = 1'b0;
      for (int k = 0; k < NO; k++) begin
         if (k == abort_k) begin
            reset = 1'b1;
            #1;
            n_tests++;
            if ({core_a, core_b, core_start, out_serial, out_valid, busy, done, error} !== '0) begin
               n_fail++;
               $display("FAIL async_reset: a=%h b=%h cs=%b os=%h ov=%b busy=%b done=%b err=%b expected all 0",
                        core_a, core_b, core_start, out_serial, out_valid, busy, done, error);
            end
            @(posedge clk); #1;
            reset = 1'b0;
            for (int j = 0; j < 3; j++) begin
               @(posedge clk); #1;
               n_tests++;
               if ({busy, done, out_valid} !== 3'b000) begin
                  n_fail++;
                  $display("FAIL post_reset: busy/done/out_valid=%b expected 000", {busy, done, out_valid});
               end
            end
            return;
         end
         exp_beat = LN'(res >> (OW - LN * (k + 1)));
         n_tests++;
         if (out_valid !== 1'b1 || out_serial !== exp_beat || busy !== 1'b1 || done !== 1'b0 || core_a !== a) begin
            n_fail++;
            $display("FAIL unload_beat%0d: ov=%b os=%h busy=%b done=%b a=%h expected 1 %h 1 0 %h",
                     k, out_valid, out_serial, busy, done, core_a, exp_beat, a);
         end
         if (noise) begin
            start    = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            in_a     = LN'($urandom);
            in_b     = LN'($urandom);
         end
         @(posedge clk); #1;
         start    = 1'b0;
         in_valid = 1'b0;
      end
      n_tests++;
      if ({done, busy, out_valid, error} !== 4'b1000 || core_a !== a || core_b !== b) begin
         n_fail++;
         $display("FAIL frame_done: done/busy/ov/err=%b a=%h b=%h expected 1000 %h %h",
                  {done, busy, out_valid, error}, core_a, core_b, a, b);
      end
      if (chain) start = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      n_tests++;
      if ({core_a, core_b, core_start, out_serial, out_valid, busy, done, error} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: outputs not all zero (a=%h b=%h busy=%b)", core_a, core_b, busy);
      end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if ({busy, done, error, out_valid} !== 4'b0000) begin
         n_fail++;
         $display("FAIL idle_after_reset: busy/done/err/ov=%b expected 0000", {busy, done, error, out_valid});
      end
   endtask

   task automatic test_basic();
      do_frame(32'h000000A5, 32'h0000003C, 0, 3, 1'b0, -1, 1'b0, 1'b0);
   endtask

   task automatic test_gaps();
      do_frame(32'h12345678, 32'h9ABCDEF0, 1, 2, 1'b0, -1, 1'b0, 1'b0);
   endtask

   task automatic test_timeout();
      do_frame(32'hDEADBEEF, 32'h01234567, 0, 0, 1'b0, -1, 1'b0, 1'b0);
      // The next accepted start must clear the sticky error.
      do_frame(32'h0F0F0F0F, 32'hF0F0F0F0, 0, 1, 1'b0, -1, 1'b0, 1'b0);
   endtask

   task automatic test_ignore();
      do_frame(32'hCAFEF00D, 32'h13579BDF, 0, 3, 1'b1, -1, 1'b0, 1'b0);
      do_frame(32'h2468ACE0, 32'h55AA33CC, 2, 2, 1'b1, -1, 1'b0, 1'b0);
   endtask

   task automatic test_abort();
      do_frame(32'h8BADF00D, 32'hFEEDFACE, 0, 2, 1'b0, 5, 1'b0, 1'b0);
      do_frame(32'h76543210, 32'hFEDCBA98, 0, 1, 1'b0, -1, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      do_frame(32'hA1B2C3D4, 32'hE5F60718, 0, 2, 1'b0, -1, 1'b0, 1'b1);
      do_frame(32'h192A3B4C, 32'h5D6E7F80, 0, 3, 1'b0, -1, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 6; n++) begin
         do_frame($urandom, $urandom, 2, int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
                  -1, 1'b0, 1'b0);
      end
   endtask

   initial begin
      reset       = 1'b1;
      start       = 1'b0;
      in_valid    = 1'b0;
      in_a        = '0;
      in_b        = '0;
      core_done   = 1'b0;
      core_result = '0;
      test_reset();
      test_basic();
      test_gaps();
      test_timeout();
      test_ignore();
      test_abort();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
